// File: rtl/instruction_sequencer_pkg.sv
// Shared instruction-format definitions for the sequencer and MasterController.
// Field order MSB->LSB: opcode[4], ins1[2], ins2[insW], ins3[insW], insLast[insD].
package instruction_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seqState_t;

    function automatic int insWOf(input int depth);
        return (depth > 2) ? depth : 2;
    endfunction

    function automatic int insDOf(input int depth, input int W);
        int d;
        d = 1 << depth;
        return (d > W) ? d : W;
    endfunction

    function automatic int insWidthOf(input int depth, input int W);
        return 4 + 2 + 2 * insWOf(depth) + insDOf(depth, W);
    endfunction

endpackage

// File: rtl/instruction_sequencer_skid.sv
// Output register with a one-entry skid buffer for the instruction stream.
// Latency: 1 cycle from memory word to instruction when not stalled.
// Backpressure: stall freezes the output; a word landing during stall parks in the skid.
module ins_skid_reg
    import instruction_sequencer_pkg::*;
#(
    parameter int insWidth = insWidthOf(3, 16)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                wordValid,
    input  logic [insWidth-1:0] word,
    input  logic                stall,
    output logic [insWidth-1:0] instruction,
    output logic                insValid,
    output logic                skidFull
);

    logic [insWidth-1:0] skidWord;

    always_ff @(posedge CLK) begin
        if (RST) begin
            instruction <= '0;
            insValid    <= 1'b0;
            skidFull    <= 1'b0;
            skidWord    <= '0;
        end else if (stall) begin
            if (wordValid) begin
                skidFull <= 1'b1;
                skidWord <= word;
            end
        end else if (skidFull) begin
            instruction <= skidWord;
            insValid    <= 1'b1;
            skidFull    <= 1'b0;
        end else begin
            // an empty slot always presents NOP so the controller never sees stale words
            instruction <= wordValid ? word : '0;
            insValid    <= wordValid;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetches progLen words from instruction memory and streams them to the MasterController.
// Latency: first instruction 2 cycles after start (memory read + output register).
// Backpressure: stall holds the output and pc; the in-flight word waits in the skid.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter  int depth    = 3,
    parameter  int W        = 16,
    parameter  int Ai       = 8,
    localparam int insWidth = insWidthOf(depth, W)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [Ai-1:0]       progLen,
    output logic [Ai-1:0]       imemAddr,
    input  logic [insWidth-1:0] imemData,
    output logic [insWidth-1:0] instruction,
    output logic                insValid,
    input  logic                stall,
    input  logic [W-1:0]        dataOut,
    output logic [W-1:0]        resData,
    output logic                resValid,
    output logic                busy,
    output logic                done
);

    seqState_t     state, stateNext;
    logic [Ai-1:0] pc, pcNext, lastPc, lastPcNext;
    logic          rdValid, skidFull, fetch, lastFetch, haltArrive, doneNext, readPend;

    assign imemAddr   = pc;
    assign busy       = (state != IDLE);
    assign haltArrive = rdValid && (imemData[insWidth-1 -: 4] == OP_HALT);

    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        lastPcNext = lastPc;
        fetch      = 1'b0;
        lastFetch  = 1'b0;
        doneNext   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (progLen == '0) begin
                        doneNext = 1'b1;
                    end else begin
                        fetch      = 1'b1;
                        lastPcNext = progLen - Ai'(1);
                        lastFetch  = (progLen == Ai'(1));
                        stateNext  = lastFetch ? DRAIN : RUN;
                        if (!lastFetch) pcNext = pc + Ai'(1);
                    end
                end
            end
            RUN: begin
                // a HALT landing from memory cancels the fetch of the following address
                if (haltArrive) begin
                    stateNext = DRAIN;
                end else if (!stall) begin
                    fetch     = 1'b1;
                    lastFetch = (pc == lastPc);
                    stateNext = lastFetch ? DRAIN : RUN;
                    if (!lastFetch) pcNext = pc + Ai'(1);
                end
            end
            DRAIN: begin
                if (!rdValid && !skidFull && insValid && !stall) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                    pcNext    = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            pc       <= '0;
            lastPc   <= '0;
            rdValid  <= 1'b0;
            done     <= 1'b0;
            readPend <= 1'b0;
            resData  <= '0;
            resValid <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            lastPc   <= lastPcNext;
            rdValid  <= fetch;
            done     <= doneNext;
            readPend <= insValid && !stall && (instruction[insWidth-1 -: 4] == OP_READ);
            resValid <= readPend;
            if (readPend) resData <= dataOut;
        end
    end

    ins_skid_reg #(.insWidth(insWidth)) u_skid (
        .CLK        (CLK),
        .RST        (RST),
        .wordValid  (rdValid),
        .word       (imemData),
        .stall      (stall),
        .instruction(instruction),
        .insValid   (insValid),
        .skidFull   (skidFull)
    );

endmodule
